addsub_serial: RTL and testbench
================================

Name: addsub_serial

Overview:
Multi-cycle, parametrised adder/subtractor for wide operands. It processes one dw-bit slice per clock, least-significant first, and ripples carry/borrow through a register. It adds a valid/ready handshake on both sides plus carry, overflow and zero flags. It serves as the wide arithmetic unit for datapaths where a full-width combinational adder is too slow or too large.

Parameters:
dw, 8, slice width in bits (bits processed per clock)
nw, 4, number of slices; operand width W = dw*nw

Ports:
clk  input  1  system clock, rising-edge
reset_n  input  1  asynchronous, active-low reset
in_valid  input  1  operands and mode presented
in_ready  output  1  block can accept a new operation
dataa  input  W  operand A
datab  input  W  operand B
add_sub  input  1  1 = A+B, 0 = A-B
out_valid  output  1  result and flags valid
out_ready  input  1  consumer accepts result
result  output  W  A+B or A-B, modulo 2^W
carry_out  output  1  add: carry out of bit W-1; sub: 1 = no borrow (A >= B unsigned)
overflow  output  1  two's-complement signed overflow
zero  output  1  result == 0

Behaviour:
- Clock and reset: one clock (clk). Reset is asynchronous and active-low (reset_n).
- Reset values: state IDLE, out_valid=0, result=0, carry_out=0, overflow=0, zero=0. in_ready=1 once reset_n deasserts. Internal slice counter and carry register clear to 0.
- Reset asserted at any time, including mid-RUN or in DONE, aborts the operation immediately. No partial result is ever presented.
- FSM:
  - IDLE: in_ready=1, out_valid=0. On in_valid & in_ready at edge T, capture dataa, datab, add_sub. Carry register loads ~add_sub (1 for subtract). Counter loads 0. Go to RUN.
  - RUN: in_ready=0. Each edge computes slice k as A[k] + (add_sub ? B[k] : ~B[k]) + carry, writes result[k*dw +: dw], updates carry, and increments k. After slice nw-1 is written, latch the flags and go to DONE.
  - DONE: out_valid=1, in_ready=0. result and flags hold stable while out_ready=0. On out_valid & out_ready, go to IDLE. in_ready rises in the following cycle; there is no same-cycle re-accept.
- Latency: accept at edge T gives out_valid high starting at edge T+nw. nw=1 is legal and gives latency 1. Throughput is at most one operation per nw+2 cycles.
- in_valid and input data are ignored outside IDLE. Captured operands are immune to input changes after acceptance.
- result bits of slices not yet computed hold their previous value during RUN. Only the DONE-state result is architecturally defined.
- Flags (computed from the captured operands):
  - carry_out = final carry register value.
  - overflow = (A[W-1] == B'[W-1]) & (result[W-1] != A[W-1]), where B' = add_sub ? B : ~B.
  - zero = ~|result.
- Flags clear to 0 on the transition to IDLE. result holds its last value until the next operation overwrites it.
- Arithmetic is modulo 2^W. There is no saturation and no width extension.
- out_ready while not in DONE has no effect.

Test Plan:
(All with dw=8, nw=4.)
1. add 0x000000FF + 0x00000001 accepted at edge T -> out_valid at T+4, result 0x00000100, carry_out 0, overflow 0, zero 0. This exercises carry across slices.
2. add 0xFFFFFFFF + 0x00000001 -> result 0x00000000, carry_out 1, zero 1, overflow 0. Separately, add 0x7FFFFFFF + 0x00000001 -> result 0x80000000, overflow 1, carry_out 0.
3. sub 0x80000000 - 0x00000001 -> result 0x7FFFFFFF, overflow 1, carry_out 1. Separately, sub 0x00000000 - 0x00000001 -> result 0xFFFFFFFF, carry_out 0, overflow 0, zero 0.
4. Backpressure: hold out_ready=0 for 5 cycles in DONE while driving in_valid=1 with new operands.
   -> result and flags stay constant and in_ready stays 0.
   -> out_ready=1 returns the FSM to IDLE, and in_ready=1 one cycle later.
   -> the new operands are accepted only then.
5. Reset mid-operation: assert reset_n=0 asynchronously during RUN slice 2.
   -> out_valid, result and flags are 0 immediately, without waiting for a clock edge.
   -> after release, in_ready=1, and the next op 0x12345678 + 0x11111111 gives 0x23456789.
6. Back-to-back randomized add/sub with random out_ready stalls, compared against a W-bit reference model, including nw=1 and dw=1 builds.
   -> every result and flag matches, and latency is exactly nw cycles.

Source files
------------

// File: rtl/addsub_serial.sv
// Bit-serial-by-slice adder/subtractor: processes one dw-bit slice per clock,
// LSB slice first, with valid/ready handshakes and carry/overflow/zero flags.
module addsub_serial #(
  parameter int dw = 8,
  parameter int nw = 4
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [dw*nw-1:0] dataa,
  input  logic [dw*nw-1:0] datab,
  input  logic             add_sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [dw*nw-1:0] result,
  output logic             carry_out,
  output logic             overflow,
  output logic             zero
);

  localparam int W  = dw * nw;
  localparam int CW = (nw > 1) ? $clog2(nw) : 1;
  localparam logic [W-1:0] SLICE_MASK = W'({dw{1'b1}});

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t         state_q, state_d;
  logic [W-1:0]   a_q, a_d;
  logic [W-1:0]   b_q, b_d;
  logic [W-1:0]   result_q, result_d;
  logic           mode_q, mode_d;
  logic           carry_q, carry_d;
  logic           cout_q, cout_d;
  logic           ovf_q, ovf_d;
  logic           zero_q, zero_d;
  logic [CW-1:0]  cnt_q, cnt_d;

  logic [31:0]    base;
  logic [W-1:0]   a_shift, b_shift;
  logic [dw-1:0]  a_slice, b_slice;
  logic [dw:0]    sum;
  logic [W-1:0]   result_merged;
  logic           b_msb_eff;

  // Slice datapath: select slice cnt_q of each operand and merge the sum back
  // into its position, leaving the other slices of result untouched.
  always_comb begin
    base          = 32'(cnt_q) * 32'(dw);
    a_shift       = a_q >> base;
    b_shift       = b_q >> base;
    a_slice       = a_shift[dw-1:0];
    b_slice       = mode_q ? b_shift[dw-1:0] : ~b_shift[dw-1:0];
    sum           = {1'b0, a_slice} + {1'b0, b_slice} + {{dw{1'b0}}, carry_q};
    result_merged = (result_q & ~(SLICE_MASK << base)) | (W'(sum[dw-1:0]) << base);
    b_msb_eff     = mode_q ? b_q[W-1] : ~b_q[W-1];
  end

  // NOTE: every signal written here gets a default first, so no path through
  // the case statement can leave one unassigned and infer a latch.
  always_comb begin
    state_d   = state_q;
    a_d       = a_q;
    b_d       = b_q;
    mode_d    = mode_q;
    carry_d   = carry_q;
    cnt_d     = cnt_q;
    result_d  = result_q;
    cout_d    = cout_q;
    ovf_d     = ovf_q;
    zero_d    = zero_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;

    unique case (state_q)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          a_d     = dataa;
          b_d     = datab;
          mode_d  = add_sub;
          // Subtraction is A + ~B + 1, so the carry-in starts at 1.
          carry_d = ~add_sub;
          cnt_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        result_d = result_merged;
        carry_d  = sum[dw];
        if (cnt_q == CW'(nw - 1)) begin
          cout_d  = sum[dw];
          ovf_d   = (a_q[W-1] == b_msb_eff) & (result_merged[W-1] != a_q[W-1]);
          zero_d  = ~|result_merged;
          state_d = DONE;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) begin
          cout_d  = 1'b0;
          ovf_d   = 1'b0;
          zero_d  = 1'b0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: result and flags are reset along with the control state so that an
  // aborted operation never leaves a partial result visible on the outputs.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= IDLE;
      a_q      <= '0;
      b_q      <= '0;
      mode_q   <= 1'b0;
      carry_q  <= 1'b0;
      cnt_q    <= '0;
      result_q <= '0;
      cout_q   <= 1'b0;
      ovf_q    <= 1'b0;
      zero_q   <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments keep every flop sampling the
      // pre-edge values, independent of statement order.
      state_q  <= state_d;
      a_q      <= a_d;
      b_q      <= b_d;
      mode_q   <= mode_d;
      carry_q  <= carry_d;
      cnt_q    <= cnt_d;
      result_q <= result_d;
      cout_q   <= cout_d;
      ovf_q    <= ovf_d;
      zero_q   <= zero_d;
    end
  end

  assign result    = result_q;
  assign carry_out = cout_q;
  assign overflow  = ovf_q;
  assign zero      = zero_q;

endmodule

// File: tb/tb_addsub_serial.sv
// Self-checking bench for addsub_serial: three builds of the same 32-bit unit
// (8x4, 32x1, 1x32) driven by directed vectors, hand sequences and random ops.
module tb_addsub_serial;

  localparam int W = 32;
  localparam int N = 3;

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         m;
    logic [W-1:0] r;
    logic         c;
    logic         v;
    logic         z;
  } vec_t;

  logic         clk = 1'b0;
  logic         reset_n = 1'b0;
  logic [W-1:0] dataa = '0;
  logic [W-1:0] datab = '0;
  logic         add_sub = 1'b0;
  logic         in_valid  [N];
  logic         out_ready [N];
  logic         in_ready  [N];
  logic         out_valid [N];
  logic [W-1:0] result    [N];
  logic         carry_out [N];
  logic         overflow  [N];
  logic         zero      [N];

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  addsub_serial #(.dw(8), .nw(4)) dut0 (
    .clk(clk), .reset_n(reset_n), .in_valid(in_valid[0]), .in_ready(in_ready[0]),
    .dataa(dataa), .datab(datab), .add_sub(add_sub), .out_valid(out_valid[0]),
    .out_ready(out_ready[0]), .result(result[0]), .carry_out(carry_out[0]),
    .overflow(overflow[0]), .zero(zero[0]));

  addsub_serial #(.dw(32), .nw(1)) dut1 (
    .clk(clk), .reset_n(reset_n), .in_valid(in_valid[1]), .in_ready(in_ready[1]),
    .dataa(dataa), .datab(datab), .add_sub(add_sub), .out_valid(out_valid[1]),
    .out_ready(out_ready[1]), .result(result[1]), .carry_out(carry_out[1]),
    .overflow(overflow[1]), .zero(zero[1]));

  addsub_serial #(.dw(1), .nw(32)) dut2 (
    .clk(clk), .reset_n(reset_n), .in_valid(in_valid[2]), .in_ready(in_ready[2]),
    .dataa(dataa), .datab(datab), .add_sub(add_sub), .out_valid(out_valid[2]),
    .out_ready(out_ready[2]), .result(result[2]), .carry_out(carry_out[2]),
    .overflow(overflow[2]), .zero(zero[2]));

  function automatic int lat(input int sel);
    case (sel)
      0:       return 4;
      1:       return 1;
      default: return 32;
    endcase
  endfunction

  task automatic check(input string name, input logic [W-1:0] got, input logic [W-1:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, got, exp, $time);
    end
  endtask

  // Reference: whole-word arithmetic and signed-overflow rules.
  task automatic model(input logic [W-1:0] a, input logic [W-1:0] b, input logic m,
                       output logic [W-1:0] r, output logic c, output logic v,
                       output logic z);
    logic [W:0] s;
    if (m) begin
      s = {1'b0, a} + {1'b0, b};
      r = s[W-1:0];
      c = s[W];
      v = (a[W-1] == b[W-1]) && (r[W-1] != a[W-1]);
    end else begin
      r = a - b;
      c = (a >= b);
      v = (a[W-1] != b[W-1]) && (r[W-1] != a[W-1]);
    end
    z = (r == '0);
  endtask

  // Present an operation; returns at the negedge after the accepting edge.
  task automatic issue(input int sel, input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic m);
    int guard;
    guard = 0;
    @(negedge clk);
    while (!in_ready[sel] && guard < 200) begin
      @(negedge clk);
      guard++;
    end
    check($sformatf("in_ready_wait[%0d]", sel), 32'(in_ready[sel]), 32'd1);
    dataa = a;
    datab = b;
    add_sub = m;
    in_valid[sel] = 1'b1;
    @(negedge clk);
    in_valid[sel] = 1'b0;
    dataa = $urandom;
    datab = $urandom;
    add_sub = $urandom_range(0, 1) != 0;
  endtask

  // Count edges from acceptance to out_valid, then compare result and flags.
  task automatic collect(input int sel, input logic [W-1:0] r, input logic c,
                         input logic v, input logic z);
    int cnt;
    cnt = 0;
    while (!out_valid[sel] && cnt < 200) begin
      @(negedge clk);
      cnt++;
    end
    check($sformatf("latency[%0d]", sel), 32'(cnt), 32'(lat(sel)));
    check($sformatf("result[%0d]", sel), result[sel], r);
    check($sformatf("carry_out[%0d]", sel), 32'(carry_out[sel]), 32'(c));
    check($sformatf("overflow[%0d]", sel), 32'(overflow[sel]), 32'(v));
    check($sformatf("zero[%0d]", sel), 32'(zero[sel]), 32'(z));
  endtask

  // Stall in DONE for a while, then hand the result off and check the return to IDLE.
  task automatic finish_op(input int sel, input int stall, input logic [W-1:0] r);
    out_ready[sel] = 1'b0;
    for (int i = 0; i < stall; i++) begin
      @(negedge clk);
      check($sformatf("stall_valid[%0d]", sel), 32'(out_valid[sel]), 32'd1);
      check($sformatf("stall_result[%0d]", sel), result[sel], r);
    end
    out_ready[sel] = 1'b1;
    @(negedge clk);
    out_ready[sel] = 1'b0;
    check($sformatf("post_valid[%0d]", sel), 32'(out_valid[sel]), 32'd0);
    check($sformatf("post_ready[%0d]", sel), 32'(in_ready[sel]), 32'd1);
    check($sformatf("post_flags[%0d]", sel),
          {29'd0, carry_out[sel], overflow[sel], zero[sel]}, 32'd0);
  endtask

  vec_t vecs [7];

  initial begin
    logic [W-1:0] ra, rb, er;
    logic         rm, ec, ev, ez;

    for (int i = 0; i < N; i++) begin
      in_valid[i]  = 1'b0;
      out_ready[i] = 1'b0;
    end

    vecs[0] = '{32'h000000FF, 32'h00000001, 1'b1, 32'h00000100, 1'b0, 1'b0, 1'b0};
    vecs[1] = '{32'hFFFFFFFF, 32'h00000001, 1'b1, 32'h00000000, 1'b1, 1'b0, 1'b1};
    vecs[2] = '{32'h7FFFFFFF, 32'h00000001, 1'b1, 32'h80000000, 1'b0, 1'b1, 1'b0};
    vecs[3] = '{32'h80000000, 32'h00000001, 1'b0, 32'h7FFFFFFF, 1'b1, 1'b1, 1'b0};
    vecs[4] = '{32'h00000000, 32'h00000001, 1'b0, 32'hFFFFFFFF, 1'b0, 1'b0, 1'b0};
    vecs[5] = '{32'h00000005, 32'h00000005, 1'b0, 32'h00000000, 1'b1, 1'b0, 1'b1};
    vecs[6] = '{32'h80000000, 32'h80000000, 1'b1, 32'h00000000, 1'b1, 1'b1, 1'b1};

    // Reset state.
    repeat (3) @(negedge clk);
    for (int s = 0; s < N; s++) begin
      check($sformatf("rst_valid[%0d]", s), 32'(out_valid[s]), 32'd0);
      check($sformatf("rst_result[%0d]", s), result[s], 32'd0);
      check($sformatf("rst_flags[%0d]", s),
            {29'd0, carry_out[s], overflow[s], zero[s]}, 32'd0);
    end
    reset_n = 1'b1;
    @(negedge clk);
    for (int s = 0; s < N; s++)
      check($sformatf("rst_in_ready[%0d]", s), 32'(in_ready[s]), 32'd1);

    // Directed vectors on every build.
    for (int s = 0; s < N; s++) begin
      for (int i = 0; i < 7; i++) begin
        issue(s, vecs[i].a, vecs[i].b, vecs[i].m);
        collect(s, vecs[i].r, vecs[i].c, vecs[i].v, vecs[i].z);
        finish_op(s, i % 2, vecs[i].r);
      end
    end

    // Backpressure with new operands waiting on the input side.
    issue(0, 32'h0000FFFF, 32'h00000001, 1'b1);
    collect(0, 32'h00010000, 1'b0, 1'b0, 1'b0);
    dataa = 32'h11111111;
    datab = 32'h22222222;
    add_sub = 1'b1;
    in_valid[0] = 1'b1;
    out_ready[0] = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("bp_result", result[0], 32'h00010000);
      check("bp_flags", {29'd0, carry_out[0], overflow[0], zero[0]}, 32'd0);
      check("bp_in_ready", 32'(in_ready[0]), 32'd0);
      check("bp_out_valid", 32'(out_valid[0]), 32'd1);
    end
    out_ready[0] = 1'b1;
    @(negedge clk);
    out_ready[0] = 1'b0;
    check("bp_idle_valid", 32'(out_valid[0]), 32'd0);
    check("bp_idle_ready", 32'(in_ready[0]), 32'd1);
    @(negedge clk);
    in_valid[0] = 1'b0;
    check("bp_accepted", 32'(in_ready[0]), 32'd0);
    collect(0, 32'h33333333, 1'b0, 1'b0, 1'b0);
    finish_op(0, 0, 32'h33333333);

    // Asynchronous reset during RUN, slice 2.
    issue(0, 32'hFFFFFFFF, 32'h01010101, 1'b1);
    @(negedge clk);
    @(negedge clk);
    check("mid_run_busy", 32'(in_ready[0]), 32'd0);
    #2 reset_n = 1'b0;
    #1;
    check("abort_valid", 32'(out_valid[0]), 32'd0);
    check("abort_result", result[0], 32'd0);
    check("abort_flags", {29'd0, carry_out[0], overflow[0], zero[0]}, 32'd0);
    #1 reset_n = 1'b1;
    @(negedge clk);
    check("abort_in_ready", 32'(in_ready[0]), 32'd1);
    check("abort_no_valid", 32'(out_valid[0]), 32'd0);
    issue(0, 32'h12345678, 32'h11111111, 1'b1);
    collect(0, 32'h23456789, 1'b0, 1'b0, 1'b0);
    finish_op(0, 1, 32'h23456789);

    // Randomised operations against the reference model.
    for (int s = 0; s < N; s++) begin
      for (int i = 0; i < 40; i++) begin
        ra = $urandom;
        rb = $urandom;
        case ($urandom_range(0, 5))
          0: rb = ra;
          1: ra = 32'h80000000;
          2: rb = 32'hFFFFFFFF;
          default: ;
        endcase
        rm = $urandom_range(0, 1) != 0;
        model(ra, rb, rm, er, ec, ev, ez);
        issue(s, ra, rb, rm);
        collect(s, er, ec, ev, ez);
        finish_op(s, $urandom_range(0, 3), er);
      end
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
